// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks {x,y,z} through all eight input vectors, samples F/Fn
// after a settle delay and publishes minterm/maxterm masks once per complete scan.
module truth_table_scanner #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       f_in,
   input  logic       fn_in,
   output logic       x,
   output logic       y,
   output logic       z,
   output logic       busy,
   output logic       done,
   output logic [7:0] minterm_mask,
   output logic [7:0] maxterm_mask,
   output logic [3:0] minterm_count,
   output logic       mismatch
);
   // state  | meaning
   // IDLE   | waiting for start; result outputs hold the last published scan
   // SETTLE | vector driven on x/y/z, waiting for the device under scan
   // SAMPLE | f_in/fn_in captured into shadow bit [idx] at the ending edge
   // DONE   | results published, one-cycle done pulse
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] idx;
   logic [2:0] idx_nxt;
   logic [3:0] settle_cnt;
   logic       settle_tc;
   logic [7:0] shadow_min;
   logic [7:0] shadow_max;
   logic       mismatch_acc;
   logic [7:0] min_final;
   logic [7:0] max_final;
   logic       mismatch_final;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   assign settle_tc = (settle_cnt == 4'(SETTLE_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SETTLE;
         SETTLE:  if (settle_tc) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = (idx == 3'd7) ? DONE : SETTLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // idx stops at 7 on the last sample so no ninth vector is ever driven
   always_comb begin
      idx_nxt = idx;
      if (state == IDLE && start)              idx_nxt = 3'd0;
      else if (state == SAMPLE && idx != 3'd7) idx_nxt = idx + 3'd1;
   end

   // Shadow state merged with the sample currently being taken
   always_comb begin
      min_final      = shadow_min;
      max_final      = shadow_max;
      min_final[idx] = f_in;
      max_final[idx] = fn_in;
      mismatch_final = mismatch_acc | (f_in == fn_in);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx           <= '0;
         settle_cnt    <= '0;
         shadow_min    <= '0;
         shadow_max    <= '0;
         mismatch_acc  <= 1'b0;
         {x, y, z}     <= 3'b000;
         minterm_mask  <= '0;
         maxterm_mask  <= '0;
         minterm_count <= '0;
         mismatch      <= 1'b0;
      end else begin
         idx       <= idx_nxt;
         {x, y, z} <= (state_nxt == SETTLE || state_nxt == SAMPLE) ? idx_nxt : 3'b000;
         case (state)
            IDLE: begin
               if (start) begin
                  settle_cnt   <= '0;
                  shadow_min   <= '0;
                  shadow_max   <= '0;
                  mismatch_acc <= 1'b0;
               end
            end
            SETTLE: settle_cnt <= settle_tc ? 4'd0 : settle_cnt + 4'd1;
            SAMPLE: begin
               settle_cnt   <= '0;
               shadow_min   <= min_final;
               shadow_max   <= max_final;
               mismatch_acc <= mismatch_final;
               if (idx == 3'd7) begin
                  minterm_mask  <= min_final;
                  maxterm_mask  <= max_final;
                  minterm_count <= popcount8(min_final);
                  mismatch      <= mismatch_final;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: two instances (SETTLE_CYCLES 2 and 1)
// scanning tabulated devices, with an independent monitor checking every cycle.
module tb_truth_table_scanner;
   localparam int S0 = 2;
   localparam int S1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_v[2];
   logic       start_v[2];
   logic [7:0] tt_f[2];
   logic [7:0] tt_fn[2];
   logic [1:0] glitch[2];
   logic       noise_on[2];
   logic [2:0] xyz[2];
   logic       busy[2];
   logic       done[2];
   logic [7:0] mn_o[2];
   logic [7:0] mx_o[2];
   logic [3:0] cnt_o[2];
   logic       mis_o[2];

   truth_table_scanner #(.SETTLE_CYCLES(S0)) dut0 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
      .f_in(tt_f[0][xyz[0]] ^ glitch[0][0]), .fn_in(tt_fn[0][xyz[0]] ^ glitch[0][1]),
      .x(xyz[0][2]), .y(xyz[0][1]), .z(xyz[0][0]), .busy(busy[0]), .done(done[0]),
      .minterm_mask(mn_o[0]), .maxterm_mask(mx_o[0]), .minterm_count(cnt_o[0]),
      .mismatch(mis_o[0]));

   truth_table_scanner #(.SETTLE_CYCLES(S1)) dut1 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
      .f_in(tt_f[1][xyz[1]] ^ glitch[1][0]), .fn_in(tt_fn[1][xyz[1]] ^ glitch[1][1]),
      .x(xyz[1][2]), .y(xyz[1][1]), .z(xyz[1][0]), .busy(busy[1]), .done(done[1]),
      .minterm_mask(mn_o[1]), .maxterm_mask(mx_o[1]), .minterm_count(cnt_o[1]),
      .mismatch(mis_o[1]));

   typedef struct {
      int         g;
      logic [7:0] mn;
      logic [7:0] mx;
      logic [3:0] c;
      logic       m;
      int         acc;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] pub_mn[2];
   logic [7:0] pub_mx[2];
   logic [3:0] pub_c[2];
   logic       pub_m[2];
   int         cur_acc[2];
   int         last_done[2];
   int         prev_done[2];
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   bit         mon_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int per(int g);
      return ((g == 0) ? S0 : S1) + 1;
   endfunction

   function automatic int first_of(int g);
      foreach (sbq[i]) if (sbq[i].g == g) return i;
      return -1;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // F = ~x~yz + ~xyz + x~y, evaluated per vector from the boolean expression
   function automatic logic [7:0] func_a();
      logic [7:0] t;
      logic xx, yy, zz;
      for (int v = 0; v < 8; v++) begin
         xx = (v / 4) % 2 == 1;
         yy = (v / 2) % 2 == 1;
         zz = v % 2 == 1;
         t[v] = (!xx && !yy && zz) || (!xx && yy && zz) || (xx && !yy);
      end
      return t;
   endfunction

   // Reference: the published masks are the device truth tables themselves
   task automatic expect_scan(int g, int acc);
      exp_t e;
      e.g   = g;
      e.mn  = tt_f[g];
      e.mx  = tt_fn[g];
      e.c   = 4'($countones(tt_f[g]));
      e.m   = (~(tt_f[g] ^ tt_fn[g])) != 8'h00;
      e.acc = acc;
      sbq.push_back(e);
   endtask

   // Inputs are scrambled whenever the scanner is not in its sample cycle
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         int  k;
         bit  in_sample;
         k = cyc - cur_acc[g];
         in_sample = (k >= 0) && (k < 8 * per(g)) && ((k % per(g)) == per(g) - 1);
         glitch[g] = (noise_on[g] && !in_sample) ? 2'($urandom) : 2'b00;
      end
   end

   always @(negedge clk) begin
      if (mon_on) begin
         for (int g = 0; g < 2; g++) begin
            int   i;
            int   k;
            int   exp_xyz;
            exp_t e;
            i = first_of(g);
            if (i >= 0 && cyc >= sbq[i].acc) begin
               k = cyc - sbq[i].acc;
               exp_xyz = (k < 8 * per(g)) ? k / per(g) : 0;
               chk("scan_xyz", 32'(xyz[g]), 32'(exp_xyz));
               chk("scan_busy", 32'(busy[g]), 32'd1);
               if (k == 8 * per(g)) chk("done_pulse", 32'(done[g]), 32'd1);
            end else if (i < 0) begin
               chk("idle_busy", 32'(busy[g]), 32'd0);
               chk("idle_xyz", 32'(xyz[g]), 32'd0);
            end
            if (done[g]) begin
               if (i < 0) chk("spurious_done", 32'(done[g]), 32'd0);
               else begin
                  e = sbq[i];
                  sbq.delete(i);
                  chk("done_time", 32'(cyc), 32'(e.acc + 8 * per(g)));
                  chk("minterm_mask", 32'(mn_o[g]), 32'(e.mn));
                  chk("maxterm_mask", 32'(mx_o[g]), 32'(e.mx));
                  chk("minterm_count", 32'(cnt_o[g]), 32'(e.c));
                  chk("mismatch", 32'(mis_o[g]), 32'(e.m));
                  pub_mn[g] = e.mn;
                  pub_mx[g] = e.mx;
                  pub_c[g]  = e.c;
                  pub_m[g]  = e.m;
                  prev_done[g] = last_done[g];
                  last_done[g] = cyc;
               end
            end else begin
               chk("result_hold", 32'({mn_o[g], mx_o[g], cnt_o[g], mis_o[g]}),
                   32'({pub_mn[g], pub_mx[g], pub_c[g], pub_m[g]}));
            end
         end
      end
   end

   task automatic wait_idle(int g);
      for (int n = 0; n < 200 && first_of(g) >= 0; n++) @(negedge clk);
      chk("drain_timeout", 32'(first_of(g) >= 0), 32'd0);
      while (first_of(g) >= 0) sbq.delete(first_of(g));
      @(negedge clk);
   endtask

   task automatic scan(int g, logic [7:0] f, logic [7:0] fn, bit noise, bit poke);
      @(negedge clk);
      tt_f[g]     = f;
      tt_fn[g]    = fn;
      noise_on[g] = noise;
      cur_acc[g]  = cyc + 1;
      expect_scan(g, cyc + 1);
      start_v[g] = 1'b1;
      @(negedge clk);
      start_v[g] = 1'b0;
      if (poke) begin
         for (int n = 0; n < 8 * per(g) - 2; n++) begin
            start_v[g] = 1'($urandom);
            @(negedge clk);
         end
         start_v[g] = 1'b0;
      end
      wait_idle(g);
      noise_on[g] = 1'b0;
   endtask

   task automatic reset_pulse(int g);
      @(negedge clk);
      rst_v[g] = 1'b1;
      @(posedge clk);
      #1;
      while (first_of(g) >= 0) sbq.delete(first_of(g));
      pub_mn[g] = '0;
      pub_mx[g] = '0;
      pub_c[g]  = '0;
      pub_m[g]  = 1'b0;
      cur_acc[g] = -1000;
      @(negedge clk);
      rst_v[g] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc1;
      int acc2;
      for (int g = 0; g < 2; g++) begin
         rst_v[g] = 1'b1; start_v[g] = 1'b0; tt_f[g] = '0; tt_fn[g] = '0;
         glitch[g] = '0; noise_on[g] = 1'b0; cur_acc[g] = -1000;
         pub_mn[g] = '0; pub_mx[g] = '0; pub_c[g] = '0; pub_m[g] = 1'b0;
         last_done[g] = 0; prev_done[g] = 0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++)
         chk("reset_outputs", 32'({xyz[g], busy[g], done[g], mn_o[g], mx_o[g], cnt_o[g], mis_o[g]}), 32'd0);
      rst_v[0] = 1'b0;
      rst_v[1] = 1'b0;
      mon_on = 1'b1;

      // (a) F with Fn = ~F, stray start pulses and scrambled inputs outside SAMPLE
      scan(0, func_a(), ~func_a(), 1'b1, 1'b1);
      chk("a_minterm", 32'(mn_o[0]), 32'h3A);
      chk("a_maxterm", 32'(mx_o[0]), 32'hC5);
      chk("a_count", 32'(cnt_o[0]), 32'd4);
      chk("a_mismatch", 32'(mis_o[0]), 32'd0);

      // (b) all ones: count must reach 8
      scan(0, 8'hFF, 8'h00, 1'b1, 1'b0);
      chk("b_count", 32'(cnt_o[0]), 32'd8);
      chk("b_minterm", 32'(mn_o[0]), 32'hFF);

      // (c) f_in = fn_in = z
      scan(0, 8'hAA, 8'hAA, 1'b0, 1'b0);
      chk("c_maxterm", 32'(mx_o[0]), 32'hAA);
      chk("c_mismatch", 32'(mis_o[0]), 32'd1);

      // (d) scan (a), then abort a second scan at its tenth edge
      scan(0, func_a(), ~func_a(), 1'b0, 1'b0);
      @(negedge clk);
      tt_f[0] = 8'h00;
      tt_fn[0] = 8'hFF;
      acc1 = cyc + 1;
      expect_scan(0, acc1);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      while (cyc < acc1 + 9) @(negedge clk);
      reset_pulse(0);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_outputs", 32'({xyz[0], done[0], mn_o[0], mx_o[0], cnt_o[0], mis_o[0]}), 32'd0);
      repeat (40) @(negedge clk);

      // reset wins over start on the same edge
      @(negedge clk);
      rst_v[0] = 1'b1;
      start_v[0] = 1'b1;
      @(negedge clk);
      rst_v[0] = 1'b0;
      start_v[0] = 1'b0;
      chk("rst_over_start", 32'(busy[0]), 32'd0);
      repeat (3) @(negedge clk);

      // (e) start held high: second accept one IDLE cycle after DONE
      @(negedge clk);
      tt_f[0] = func_a();
      tt_fn[0] = ~func_a();
      acc1 = cyc + 1;
      acc2 = acc1 + 8 * per(0) + 2;
      expect_scan(0, acc1);
      expect_scan(0, acc2);
      start_v[0] = 1'b1;
      while (cyc < acc2) @(negedge clk);
      start_v[0] = 1'b0;
      wait_idle(0);
      // edges from the end of the first done pulse to the rise of the second
      chk("b2b_gap", 32'(last_done[0] - (prev_done[0] + 1)), 32'd25);
      chk("b2b_result", 32'(mn_o[0]), 32'h3A);

      // (f) one-cycle settle
      scan(1, func_a(), ~func_a(), 1'b1, 1'b1);
      chk("f_minterm", 32'(mn_o[1]), 32'h3A);

      // randomized devices on both instances
      for (int n = 0; n < 10; n++) begin
         int g;
         g = int'($urandom_range(0, 1));
         scan(g, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end

      mon_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 2, number of cycles each input vector is held before F/Fn are sampled; legal range 1..15.
REQ-002 The block SHALL have these ports:
  clk  input  1  single clock; all state changes on rising edge.
  rst  input  1  reset; synchronous, active-high.
  start  input  1  scan request; sampled only in IDLE.
  f_in  input  1  F output of the device under scan.
  fn_in  input  1  Fn output of the device under scan.
  x  output  1  drive input x, MSB of vector index.
  y  output  1  drive input y, middle bit of vector index.
  z  output  1  drive input z, LSB of vector index.
  busy  output  1  high in every state except IDLE.
  done  output  1  one-cycle pulse when results update.
  minterm_mask  output  8  bit i = sampled f_in for vector i = {x,y,z}.
  maxterm_mask  output  8  bit i = sampled fn_in for vector i.
  minterm_count  output  4  number of 1s in minterm_mask, 0..8.
  mismatch  output  1  1 if f_in == fn_in at any sample of the last scan.

Function
REQ-003 The FSM SHALL have four states: IDLE, SETTLE, SAMPLE, DONE.
REQ-004 In IDLE with start=1 at a clock edge, the FSM SHALL move to SETTLE, clear the vector index to 0, clear the settle counter, and clear the internal shadow masks and mismatch accumulator.
REQ-005 {x,y,z} SHALL be registered outputs equal to the 3-bit vector index while in SETTLE or SAMPLE, and 000 in IDLE and DONE.
REQ-006 SETTLE SHALL last exactly SETTLE_CYCLES cycles per vector, then transition to SAMPLE.
REQ-007 SAMPLE SHALL last exactly one cycle; at its ending edge, f_in is written to shadow minterm bit [index] and fn_in to shadow maxterm bit [index], and mismatch_acc |= (f_in == fn_in).
REQ-008 After SAMPLE with index < 7, the index SHALL increment and the FSM SHALL return to SETTLE with the settle counter cleared.
REQ-009 After SAMPLE with index = 7, the FSM SHALL go to DONE; the index SHALL NOT wrap into a ninth vector.
REQ-010 On entry to DONE, minterm_mask, maxterm_mask, mismatch and minterm_count SHALL load from the shadow registers and the final sample together.
REQ-011 done SHALL be 1 only in the DONE cycle; DONE SHALL always return to IDLE on the next edge.
REQ-012 The first done SHALL occur exactly 8*(SETTLE_CYCLES+1) edges after the accepting edge: 24 for the default.
REQ-013 Result outputs SHALL hold their values from one DONE until the next DONE or reset, including for the whole duration of a later scan.
REQ-014 start SHALL be ignored in SETTLE, SAMPLE and DONE; there is no queuing.
REQ-015 start held high continuously SHALL begin a new scan on the edge after DONE, giving back-to-back scans with one IDLE cycle between them.
REQ-016 minterm_count SHALL be the population count of the loaded minterm_mask, zero-extended to 4 bits; the value 8 SHALL be representable.
REQ-017 f_in and fn_in SHALL be ignored outside SAMPLE.

Reset
REQ-018 rst=1 at an edge SHALL force IDLE and clear every output to 0: x, y, z, busy, done, both masks, minterm_count and mismatch.
REQ-019 rst=1 at an edge SHALL also clear the index, the settle counter, the shadow registers and mismatch_acc.
REQ-020 Reset asserted mid-scan SHALL abort the scan with no done pulse and no partial result published.
REQ-021 rst SHALL take priority over start at the same edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  a) SETTLE_CYCLES=2; F = ~x~yz + ~xyz + x~y modelled combinationally, Fn = ~F; pulse start -> done 24 edges later, minterm_mask=0x3A, maxterm_mask=0xC5, minterm_count=4, mismatch=0.
  b) f_in tied 1, fn_in tied 0 -> minterm_mask=0xFF, maxterm_mask=0x00, minterm_count=8, mismatch=0.
  c) f_in = fn_in = z -> minterm_mask=0xAA, maxterm_mask=0xAA, mismatch=1.
  d) Scan (a) completes, then rst pulsed at edge 10 of a second scan with f_in tied 0 -> all outputs 0, no done, busy=0 on the next cycle.
  e) start held high through two scans of the (a) function -> two done pulses 25 edges apart, results identical; start pulses issued during a scan have no effect.
  f) SETTLE_CYCLES=1 -> done 16 edges after accept; {x,y,z} steps 000..111 every 2 cycles, then returns to 000.
